spectrum_bin_buffer: RTL and testbench

- Double-buffered per-bin column-height store between the FFT magnitude stage and the column drawer.
- Accepts one magnitude per frequency bin, in order, and scales it to screen height.
- Applies peak-hold with per-frame decay against the previously displayed frame.
- Presents the displayed frame as `curr_peak` for the drawer's current x. Raises `is_idle` when a fresh frame has been swapped in and is ready to draw.

---
 rtl/spectrum_bin_buffer.sv | 130 +++++++++++++
 tb/tb_spectrum_bin_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_bin_buffer.sv
// spectrum_bin_buffer
// Double-buffered per-bin column-height store sitting between the FFT
// magnitude stage and the column drawer. One bank is shown to the drawer
// while the other is filled with freshly scaled heights that include a
// peak-hold with per-frame decay against the displayed frame. Banks swap
// only while the drawer is not drawing, so a drawing pass always sees a
// stable frame.
module spectrum_bin_buffer #(
  parameter int N     = 1024,
  parameter int MAG_W = 10,
  parameter int SHIFT = 1,
  parameter int MAX_H = 479,
  parameter int DECAY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_bin,
  input  logic [MAG_W-1:0] in_mag,
  input  logic             draw_state,
  input  logic [9:0]       rd_x,
  output logic [8:0]       curr_peak,
  output logic             is_idle,
  output logic             seq_err,
  output logic [7:0]       frame_cnt
);

  localparam int               BINS     = N / 2 + 1;
  localparam logic [9:0]       BINS_X   = 10'(BINS);
  localparam logic [9:0]       LAST_BIN = 10'(BINS - 1);
  localparam logic [MAG_W-1:0] MAX_H_M  = MAG_W'(MAX_H);
  localparam logic [8:0]       MAX_H_H  = 9'(MAX_H);
  localparam logic [8:0]       DECAY_H  = 9'(DECAY);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [8:0]       bank0 [BINS];
  logic [8:0]       bank1 [BINS];
  logic             bank_sel;
  logic [0:0]       state;
  logic [9:0]       exp_bin;

  logic [8:0]       disp_at_bin;
  logic [MAG_W-1:0] shifted;
  logic [8:0]       scaled_h;
  logic [8:0]       decayed_h;
  logic [8:0]       new_h;
  logic             accept;
  logic             bin_match;
  logic             last_bin;
  logic             swap;

  assign in_ready  = (state == FILL);
  assign accept    = in_ready && in_valid;
  assign bin_match = (in_bin == exp_bin);
  assign last_bin  = (exp_bin == LAST_BIN);
  assign swap      = (state == PEND) && !draw_state;

  // Drawer read port: zero-latency lookup of the display bank, 0 past the last bin
  always_comb begin
    curr_peak = '0;
    if (rd_x < BINS_X) begin
      curr_peak = bank_sel ? bank1[rd_x] : bank0[rd_x];
    end
  end

  // Scale the incoming magnitude and peak-hold it against the decayed displayed height
  always_comb begin
    disp_at_bin = '0;
    if (in_bin < BINS_X) begin
      disp_at_bin = bank_sel ? bank1[in_bin] : bank0[in_bin];
    end
    shifted   = in_mag >> SHIFT;
    scaled_h  = (shifted > MAX_H_M) ? MAX_H_H : 9'(shifted);
    decayed_h = (disp_at_bin >= DECAY_H) ? (disp_at_bin - DECAY_H) : '0;
    new_h     = (scaled_h > decayed_h) ? scaled_h : decayed_h;
  end

  // Bank storage: in-order samples land in the bank that is not being displayed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BINS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (accept && bin_match) begin
      if (bank_sel) begin
        bank0[exp_bin] <= new_h;
      end else begin
        bank1[exp_bin] <= new_h;
      end
    end
  end

  // Frame sequencing: fill in bin order, then wait for the drawer to go idle and swap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      exp_bin   <= '0;
      bank_sel  <= 1'b0;
      frame_cnt <= '0;
      is_idle   <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      if (accept) begin
        if (bin_match) begin
          if (last_bin) begin
            state   <= PEND;
            exp_bin <= '0;
          end else begin
            exp_bin <= exp_bin + 10'd1;
          end
        end else begin
          seq_err <= 1'b1;
        end
      end
      if (swap) begin
        bank_sel  <= ~bank_sel;
        frame_cnt <= frame_cnt + 8'd1;
        is_idle   <= 1'b1;
        state     <= FILL;
      end else if (draw_state && is_idle) begin
        is_idle <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spectrum_bin_buffer.sv
// tb_spectrum_bin_buffer
// Directed bench for spectrum_bin_buffer. A frame-level reference model
// (display frame, frame under construction, expected bin, counters) tracks
// what the outputs must be and a compare process checks every output on
// every falling edge; literal expectations at key points pin the model.
module tb_spectrum_bin_buffer;

  localparam int BINS = 513;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_bin;
  logic [9:0] in_mag;
  logic       draw_state;
  logic [9:0] rd_x;
  logic [8:0] curr_peak;
  logic       is_idle;
  logic       seq_err;
  logic [7:0] frame_cnt;

  int vec_count  = 0;
  int miscompares = 0;

  // Reference model state
  int m_disp  [BINS];
  int m_build [BINS];
  int m_exp;
  int m_fill;
  int m_seq;
  int m_cnt;
  int m_idle;

  spectrum_bin_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .in_mag    (in_mag),
    .draw_state(draw_state),
    .rd_x      (rd_x),
    .curr_peak (curr_peak),
    .is_idle   (is_idle),
    .seq_err   (seq_err),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int expv);
    vec_count++;
    if (act != expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: one sample per bin in order, peak-hold with decay, swap when drawer idle
  always @(posedge clk or negedge reset) begin
    int h;
    int d;
    if (!reset) begin
      for (int i = 0; i < BINS; i++) begin
        m_disp[i]  = 0;
        m_build[i] = 0;
      end
      m_exp  = 0;
      m_fill = 1;
      m_seq  = 0;
      m_cnt  = 0;
      m_idle = 0;
    end else begin
      if (draw_state && m_idle != 0) m_idle = 0;
      if (m_fill != 0) begin
        if (in_valid) begin
          if (int'(in_bin) == m_exp) begin
            h = int'(in_mag) / 2;
            if (h > 479) h = 479;
            d = m_disp[m_exp] - 4;
            if (d < 0) d = 0;
            m_build[m_exp] = (h > d) ? h : d;
            if (m_exp == BINS - 1) begin
              m_fill = 0;
              m_exp  = 0;
            end else begin
              m_exp++;
            end
          end else begin
            m_seq = 1;
          end
        end
      end else if (!draw_state) begin
        m_disp = m_build;
        m_cnt  = (m_cnt + 1) % 256;
        m_idle = 1;
        m_fill = 1;
      end
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    int exp_peak;
    exp_peak = (int'(rd_x) < BINS) ? m_disp[int'(rd_x)] : 0;
    checkOutput("in_ready",  int'(in_ready),  m_fill);
    checkOutput("is_idle",   int'(is_idle),   m_idle);
    checkOutput("seq_err",   int'(seq_err),   m_seq);
    checkOutput("frame_cnt", int'(frame_cnt), m_cnt);
    checkOutput("curr_peak", int'(curr_peak), exp_peak);
  end

  task automatic applyStimulus(input int bin, input int mag);
    in_valid = 1'b1;
    in_bin   = 10'(bin);
    in_mag   = 10'(mag);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic int ramp_mag(input int k);
    return (2 * k > 1023) ? 1023 : 2 * k;
  endfunction

  task automatic send_frame(input bit ramp);
    for (int k = 0; k < BINS; k++) begin
      applyStimulus(k, ramp ? ramp_mag(k) : 0);
    end
  endtask

  task automatic peek(input int x, input int expv, input string name);
    rd_x = 10'(x);
    #1;
    checkOutput(name, int'(curr_peak), expv);
  endtask

  // Advance one clock so the pending swap takes place, then settle to the falling edge
  task automatic wait_swap();
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_bin     = '0;
    in_mag     = '0;
    draw_state = 1'b0;
    rd_x       = '0;
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] reset state");
    @(negedge clk);
    checkOutput("rst_in_ready",  int'(in_ready),  1);
    checkOutput("rst_is_idle",   int'(is_idle),   0);
    checkOutput("rst_frame_cnt", int'(frame_cnt), 0);
    checkOutput("rst_seq_err",   int'(seq_err),   0);
    @(posedge clk);
    #1;
    for (int x = 0; x <= 520; x++) begin
      rd_x = 10'(x);
      @(posedge clk);
      #1;
    end

    $display("[TB] frame 1: ramp magnitudes");
    send_frame(1'b1);
    @(negedge clk);
    checkOutput("f1_pend_in_ready", int'(in_ready), 0);
    wait_swap();
    checkOutput("f1_is_idle",   int'(is_idle),   1);
    checkOutput("f1_frame_cnt", int'(frame_cnt), 1);
    checkOutput("f1_in_ready",  int'(in_ready),  1);
    peek(100, 100, "f1_peak100");
    peek(512, 479, "f1_peak512");
    peek(600, 0,   "f1_peak600");
    peek(0,   0,   "f1_peak0");
    peek(300, 300, "f1_peak300");
    @(posedge clk);
    #1;

    $display("[TB] frames 2 and 3: zero magnitudes decay");
    send_frame(1'b0);
    wait_swap();
    peek(100, 96, "f2_peak100");
    peek(0,   0,  "f2_peak0");
    checkOutput("f2_frame_cnt", int'(frame_cnt), 2);
    @(posedge clk);
    #1;
    send_frame(1'b0);
    wait_swap();
    peek(100, 92, "f3_peak100");
    checkOutput("f3_frame_cnt", int'(frame_cnt), 3);
    @(posedge clk);
    #1;

    $display("[TB] frame 4: drawer busy holds the swap");
    rd_x       = 10'd100;
    draw_state = 1'b1;
    send_frame(1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("hold_in_ready",  int'(in_ready),  0);
    checkOutput("hold_peak100",   int'(curr_peak), 92);
    checkOutput("hold_frame_cnt", int'(frame_cnt), 3);
    checkOutput("hold_is_idle",   int'(is_idle),   0);
    @(posedge clk);
    #1;
    draw_state = 1'b0;
    @(posedge clk);
    #1;
    draw_state = 1'b1;
    @(negedge clk);
    checkOutput("rel_is_idle",   int'(is_idle),   1);
    checkOutput("rel_frame_cnt", int'(frame_cnt), 4);
    checkOutput("rel_peak100",   int'(curr_peak), 88);
    @(posedge clk);
    #1;
    draw_state = 1'b0;
    @(negedge clk);
    checkOutput("draw_clears_idle", int'(is_idle), 0);
    @(posedge clk);
    #1;

    $display("[TB] frame 5: out-of-order bin");
    applyStimulus(0, 0);
    applyStimulus(5, 0);
    @(negedge clk);
    checkOutput("seq_err_set", int'(seq_err), 1);
    @(posedge clk);
    #1;
    for (int k = 1; k < BINS; k++) begin
      applyStimulus(k, 0);
    end
    @(negedge clk);
    checkOutput("f5_pend_in_ready", int'(in_ready), 0);
    wait_swap();
    checkOutput("f5_frame_cnt", int'(frame_cnt), 5);
    checkOutput("f5_seq_err",   int'(seq_err),   1);
    peek(100, 84, "f5_peak100");
    @(posedge clk);
    #1;

    $display("[TB] reset mid-frame");
    for (int k = 0; k < 200; k++) begin
      applyStimulus(k, ramp_mag(k));
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_frame_cnt", int'(frame_cnt), 0);
    checkOutput("mid_rst_seq_err",   int'(seq_err),   0);
    checkOutput("mid_rst_in_ready",  int'(in_ready),  1);
    peek(100, 0, "mid_rst_peak100");
    @(posedge clk);
    #1;
    send_frame(1'b1);
    wait_swap();
    checkOutput("post_rst_frame_cnt", int'(frame_cnt), 1);
    checkOutput("post_rst_is_idle",   int'(is_idle),   1);
    peek(100, 100, "post_rst_peak100");
    peek(512, 479, "post_rst_peak512");
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
